// File: rtl/md_issue_ctrl_pkg.sv
// Shared muldiv select encodings, shadow FSM state codes and decode helpers.
package md_issue_ctrl_pkg;

    localparam logic [2:0] MULDIV_SELECT_LO = 3'd0;
    localparam logic [2:0] MULDIV_SELECT_HI = 3'd1;
    localparam logic [2:0] MULDIV_DO_MUL    = 3'd2;
    localparam logic [2:0] MULDIV_DO_MULU   = 3'd3;
    localparam logic [2:0] MULDIV_DO_DIV    = 3'd4;
    localparam logic [2:0] MULDIV_DO_DIVU   = 3'd5;

    typedef enum logic [1:0] {
        MdStIdle = 2'd0,
        MdStMul  = 2'd1,
        MdStDiv  = 2'd2
    } md_state_e;

    function automatic logic is_mul_sel(input logic [2:0] sel);
        return (sel == MULDIV_DO_MUL) || (sel == MULDIV_DO_MULU);
    endfunction

    function automatic logic is_div_sel(input logic [2:0] sel);
        return (sel == MULDIV_DO_DIV) || (sel == MULDIV_DO_DIVU);
    endfunction

endpackage

// File: rtl/md_sat_counter.sv
// Generic saturating up-counter for pipeline statistics; holds at all-ones.
module md_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    // Count up on inc, never wrapping past all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/md_issue_ctrl.sv
// Muldiv issue/hazard controller: gates start/write into the unit, shadows its
// busy window to stall dependent D-stage instructions, and tracks consistency.
module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned STAT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              D_md_use,
    input  logic              E_md_start,
    input  logic              E_md_we,
    input  logic [2:0]        E_md_sel,
    input  logic              md_busy,
    output logic              md_start,
    output logic              md_we,
    output logic [2:0]        md_sel,
    output logic              stall_D,
    output logic [1:0]        md_state,
    output logic              mismatch,
    output logic [STAT_W-1:0] stall_cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_state_e        state_q, state_d;
    logic             mismatch_q;
    logic             shadow_busy;

    // Write beats start on an illegal double decode; a flush kills both
    assign md_start    = E_md_start & ~req & ~E_md_we;
    assign md_we       = E_md_we & ~req;
    assign md_sel      = E_md_sel;
    assign shadow_busy = (cnt_q != '0);
    // Start cycle stalls too: the unit's busy only rises after this edge
    assign stall_D     = D_md_use & (md_start | shadow_busy);

    // Shadow state and counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= MdStIdle;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Next shadow window: write cancels, start reloads, otherwise count down
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (md_we) begin
            cnt_d   = '0;
            state_d = MdStIdle;
        end else if (md_start && is_mul_sel(E_md_sel)) begin
            cnt_d   = CNT_W'(MUL_CYCLES);
            state_d = MdStMul;
        end else if (md_start && is_div_sel(E_md_sel)) begin
            cnt_d   = CNT_W'(DIV_CYCLES);
            state_d = MdStDiv;
        end else if (!md_start && shadow_busy) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = MdStIdle;
            end
        end
    end

    // Sticky flag for any edge where the shadow and the unit disagree
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else if (shadow_busy != md_busy) begin
            mismatch_q <= 1'b1;
        end
    end

    assign md_state = state_q;
    assign mismatch = mismatch_q;

    md_sat_counter #(
        .W (STAT_W)
    ) u_stall_stat (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_D),
        .count (stall_cnt)
    );

endmodule
